mem_arbiter: RTL and testbench

Arbitrates a single-ported RAM between the instruction-fetch port and the data-memory port of the single-cycle MIPS datapath. It sits between the datapath (PC/instruction path, and the load/store path driven by dREN/dWEN from control decode) and the RAM model. Data accesses have priority, and a bounded starvation counter guarantees forward progress for fetches. A registered three-state FSM holds each grant until the RAM reports completion.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared datapath types: RAM word, RAM handshake state and the memory
// arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data has priority; a saturating starvation counter forces a fetch grant.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      merr
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

  arb_state_t       r_state;
  arb_state_t       w_next;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_dreq;
  logic             w_done;
  logic             w_icomp;
  logic             w_dcomp;

  assign w_dreq = dREN | dWEN;
  assign w_done = (ramstate == ACCESS) || (ramstate == ERROR);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Counts data completions that a pending fetch had to sit through.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                   r_starve_cnt <= '0;
    else if (!iREN || w_icomp)                   r_starve_cnt <= '0;
    else if (w_dcomp && r_starve_cnt != MAX_CNT) r_starve_cnt <= r_starve_cnt + 1'b1;
  end

  always_comb begin
    w_next   = r_state;
    w_icomp  = 1'b0;
    w_dcomp  = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = iREN;
    dwait    = w_dreq;
    merr     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_dreq && !(iREN && r_starve_cnt == MAX_CNT)) w_next = DGNT;
        else if (iREN)                                    w_next = IGNT;
      end
      IGNT: begin
        if (!iREN) begin
          w_next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          iload   = ramload;
          if (w_done) begin
            iwait   = 1'b0;
            merr    = (ramstate == ERROR);
            w_icomp = 1'b1;
            w_next  = IDLE;
          end
        end
      end
      DGNT: begin
        if (!w_dreq) begin
          w_next = IDLE;
        end else begin
          // A simultaneous read and write request is served as a write.
          ramREN   = dREN & ~dWEN;
          ramWEN   = dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          dload    = ramload;
          if (w_done) begin
            dwait   = 1'b0;
            merr    = (ramstate == ERROR);
            w_dcomp = 1'b1;
            w_next  = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected completions into a
// scoreboard; a negedge monitor pops and compares each completion it sees.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      iwait;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dwait;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      merr;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    bit    is_d;
    word_t addr;
    bit    ren;
    bit    wen;
    word_t store;
    bit    chk_load;
    word_t load;
    bit    merr;
    int    cyc;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  logic m_ic;
  logic m_dc;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .merr(merr)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit d, input word_t a, input bit ren, input bit wen,
                      input word_t st, input bit cl, input word_t ld, input bit me,
                      input int c);
    exp_t e;
    e.is_d = d; e.addr = a; e.ren = ren; e.wen = wen; e.store = st;
    e.chk_load = cl; e.load = ld; e.merr = me; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every completion must match the next scoreboard entry.
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      m_ic = iREN && !iwait;
      m_dc = (dREN || dWEN) && !dwait;
      if (m_ic || m_dc) begin
        if (sb.size() == 0) begin
          chk("unexpected_completion", {30'b0, m_ic, m_dc}, 32'h0);
        end else begin
          m_e = sb.pop_front();
          chk("cmp_port_is_data", {31'b0, m_dc}, {31'b0, m_e.is_d});
          chk("cmp_single_port",  {31'b0, m_ic && m_dc}, 32'h0);
          chk("cmp_cycle",        cyc, m_e.cyc);
          chk("cmp_ramaddr",      ramaddr, m_e.addr);
          chk("cmp_ramREN",       {31'b0, ramREN}, {31'b0, m_e.ren});
          chk("cmp_ramWEN",       {31'b0, ramWEN}, {31'b0, m_e.wen});
          if (m_e.wen) chk("cmp_ramstore", ramstore, m_e.store);
          if (m_e.chk_load) chk(m_e.is_d ? "cmp_dload" : "cmp_iload",
                                m_e.is_d ? dload : iload, m_e.load);
          chk(m_e.is_d ? "cmp_iload_idle" : "cmp_dload_idle",
              m_e.is_d ? iload : dload, 32'h0);
          chk("cmp_merr",         {31'b0, merr}, {31'b0, m_e.merr});
        end
      end else begin
        chk("merr_without_completion", {31'b0, merr}, 32'h0);
      end
    end
  end

  task automatic run_starve(input word_t ia, input word_t da);
    int c0;
    c0 = cyc;
    iREN = 1'b1; iaddr = ia; dREN = 1'b1; dWEN = 1'b0; daddr = da; ramstate = ACCESS;
    push(1, da, 1, 0, 0, 1, 32'hC000_0001, 0, c0 + 1);
    push(1, da, 1, 0, 0, 1, 32'hC000_0003, 0, c0 + 3);
    push(1, da, 1, 0, 0, 1, 32'hC000_0005, 0, c0 + 5);
    push(1, da, 1, 0, 0, 1, 32'hC000_0007, 0, c0 + 7);
    push(0, ia, 1, 0, 0, 1, 32'hC000_0009, 0, c0 + 9);
    push(1, da, 1, 0, 0, 1, 32'hC000_000B, 0, c0 + 11);
    for (int k = 0; k < 12; k++) begin
      ramload = 32'hC000_0000 | 32'(k);
      smp();
      if (k == 0) chk("starve_start_idle_ramREN", {31'b0, ramREN}, 32'h0);
      if (k == 8) chk("starve_forced_idle_iwait", {31'b0, iwait}, 32'h1);
      adv();
    end
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    smp();
    chk("starve_end_ramREN", {31'b0, ramREN}, 32'h0);
    adv();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    #2;
    chk("rst_ramREN",   {31'b0, ramREN}, 32'h0);
    chk("rst_ramWEN",   {31'b0, ramWEN}, 32'h0);
    chk("rst_ramaddr",  ramaddr, 32'h0);
    chk("rst_iwait",    {31'b0, iwait}, 32'h0);
    chk("rst_dwait",    {31'b0, dwait}, 32'h0);
    chk("rst_merr",     {31'b0, merr}, 32'h0);
    iREN = 1'b1; dREN = 1'b1;
    #1;
    chk("rst_iwait_follows", {31'b0, iwait}, 32'h1);
    chk("rst_dwait_follows", {31'b0, dwait}, 32'h1);
    chk("rst_ramREN_req",    {31'b0, ramREN}, 32'h0);
    iREN = 1'b0; dREN = 1'b0;
    adv();
    nRST = 1'b1;
    adv();

    // Single fetch with two BUSY cycles
    c0 = cyc;
    iREN = 1'b1; iaddr = 32'h0000_0040; ramstate = FREE;
    push(0, 32'h40, 1, 0, 0, 1, 32'h2008_0005, 0, c0 + 3);
    smp(); chk("fetch_c0_ramREN", {31'b0, ramREN}, 32'h0); chk("fetch_c0_iwait", {31'b0, iwait}, 32'h1); adv();
    ramstate = BUSY;
    smp(); chk("fetch_c1_ramREN", {31'b0, ramREN}, 32'h1); chk("fetch_c1_iwait", {31'b0, iwait}, 32'h1); adv();
    smp(); chk("fetch_c2_ramREN", {31'b0, ramREN}, 32'h1); chk("fetch_c2_ramaddr", ramaddr, 32'h40); adv();
    ramstate = ACCESS; ramload = 32'h2008_0005;
    smp(); chk("fetch_c3_ramREN", {31'b0, ramREN}, 32'h1); adv();
    iREN = 1'b0; ramstate = FREE;
    smp(); chk("fetch_c4_ramREN", {31'b0, ramREN}, 32'h0); adv();

    // Write completing on the first granted cycle
    c0 = cyc;
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; ramstate = ACCESS; ramload = 32'h1234_5678;
    push(1, 32'h200, 0, 1, 32'hDEAD_BEEF, 1, 32'h1234_5678, 0, c0 + 1);
    smp(); chk("write_c0_dwait", {31'b0, dwait}, 32'h1); adv();
    smp(); adv();
    dWEN = 1'b0; ramstate = FREE;
    smp(); chk("write_c2_ramWEN", {31'b0, ramWEN}, 32'h0); adv();

    // Contention: data first, fetch after one IDLE cycle
    c0 = cyc;
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100; ramstate = ACCESS; ramload = 32'hAAAA_0001;
    push(1, 32'h100, 1, 0, 0, 1, 32'hAAAA_0001, 0, c0 + 1);
    smp(); adv();
    smp(); chk("cont_c1_iwait", {31'b0, iwait}, 32'h1); chk("cont_c1_iload", iload, 32'h0); adv();
    dREN = 1'b0; ramload = 32'hBBBB_0002;
    push(0, 32'h44, 1, 0, 0, 1, 32'hBBBB_0002, 0, c0 + 3);
    smp(); chk("cont_c2_idle_ramREN", {31'b0, ramREN}, 32'h0); chk("cont_c2_iwait", {31'b0, iwait}, 32'h1); adv();
    smp(); adv();
    iREN = 1'b0; ramstate = FREE;
    smp(); adv();

    // Starvation bound
    run_starve(32'h48, 32'h300);

    // ERROR during a data grant, merr must not repeat in the next IDLE cycle
    c0 = cyc;
    dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
    push(1, 32'h400, 1, 0, 0, 0, 32'h0, 1, c0 + 2);
    smp(); adv();
    smp(); chk("err_c1_dwait", {31'b0, dwait}, 32'h1); adv();
    ramstate = ERROR;
    smp(); adv();
    smp(); chk("err_c3_merr_pulse", {31'b0, merr}, 32'h0); chk("err_c3_ramREN", {31'b0, ramREN}, 32'h0); adv();
    dREN = 1'b0; ramstate = FREE;
    smp(); chk("err_c4_merr", {31'b0, merr}, 32'h0); adv();

    // Fetch withdrawn during BUSY
    c0 = cyc;
    iREN = 1'b1; iaddr = 32'h50; ramstate = BUSY;
    smp(); adv();
    smp(); chk("wd_c1_ramREN", {31'b0, ramREN}, 32'h1); adv();
    iREN = 1'b0;
    smp(); chk("wd_c2_ramREN_drop", {31'b0, ramREN}, 32'h0); chk("wd_c2_iwait", {31'b0, iwait}, 32'h0); adv();
    iREN = 1'b1; ramstate = ACCESS; ramload = 32'h5050_5050;
    push(0, 32'h50, 1, 0, 0, 1, 32'h5050_5050, 0, c0 + 4);
    smp(); chk("wd_c3_idle_ramREN", {31'b0, ramREN}, 32'h0); adv();
    smp(); adv();
    iREN = 1'b0; ramstate = FREE;
    smp(); adv();

    // Reset during BUSY of a fetch, after the counter has advanced
    c0 = cyc;
    iREN = 1'b1; iaddr = 32'h60; dREN = 1'b1; daddr = 32'h500; ramstate = ACCESS; ramload = 32'h1111_0000;
    push(1, 32'h500, 1, 0, 0, 1, 32'h1111_0000, 0, c0 + 1);
    push(1, 32'h500, 1, 0, 0, 1, 32'h1111_0000, 0, c0 + 3);
    for (int k = 0; k < 4; k++) begin smp(); adv(); end
    dREN = 1'b0; ramstate = BUSY;
    smp(); adv();
    smp(); chk("rstmid_c5_ramREN", {31'b0, ramREN}, 32'h1); chk("rstmid_c5_ramaddr", ramaddr, 32'h60); adv();
    nRST = 1'b0;
    #1;
    chk("rstmid_ramREN_drop", {31'b0, ramREN}, 32'h0);
    chk("rstmid_ramaddr",     ramaddr, 32'h0);
    chk("rstmid_iwait",       {31'b0, iwait}, 32'h1);
    smp(); adv();
    nRST = 1'b1;
    run_starve(32'h64, 32'h504);

    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
